aes_ctr_stream: RTL

- Parametrised AES-256 counter-mode stream engine that succeeds the single-block encryption top.
- Generates counter blocks from a loaded IV and issues them to an external AES-256 block core over a valid/ready request/response interface.
- Buffers the returned keystream in a FIFO and XORs it with a streaming plaintext/ciphertext input. CTR is symmetric, so one block serves both encrypt and decrypt.
- Sits between the DMA-side byte stream and the iterative AES core.

---
 rtl/aes_ctr_stream.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: AES-256 counter-mode stream engine.
// Issues counter blocks to an external AES-256 block core, buffers the returned
// keystream and XORs it with the input byte stream (encrypt and decrypt alike).
// Optional build macro AES_CTR_WRAP_ERR_EN: adds ctr_wrap_err and stops request
// issue instead of letting the counter field wrap.
//
// state | meaning
// IDLE  | waiting for start; no requests, no stream traffic
// RUN   | issuing counter blocks, consuming input beats
// DRAIN | message ended; discarding late keystream, waiting for output to empty
module aes_ctr_stream #(
    parameter int CTR_W    = 32,
    parameter int KS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] iv,
    input  logic [255:0] key_i,
    output logic         busy,
    output logic         aes_req_valid,
    input  logic         aes_req_ready,
    output logic [127:0] aes_req_block,
    output logic [255:0] aes_key,
    input  logic         aes_resp_valid,
    input  logic [127:0] aes_resp_block,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    input  logic [15:0]  s_keep,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic [15:0]  m_keep,
    output logic         m_last
`ifdef AES_CTR_WRAP_ERR_EN
    ,
    output logic         ctr_wrap_err
`endif
);

    localparam int PTR_W = $clog2(KS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Selects the incrementing low field of the counter block.
    localparam logic [127:0] LO_MASK = {128{1'b1}} >> (128 - CTR_W);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(KS_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [127:0]      ctr;
    logic [255:0]      key_reg;
    logic [127:0]      ks_mem [KS_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  in_flight;
    logic [CNT_W:0]    credit_used;
    logic              issue_ok;
    logic              req_fire;
    logic              resp_dec;
    logic              push;
    logic              pop;
    logic              s_fire;
    logic [127:0]      ctr_inc;
    logic [127:0]      xor_data;
    logic [127:0]      masked_data;

`ifdef AES_CTR_WRAP_ERR_EN
    logic wrap_err;
    logic ctr_at_max;
    assign ctr_at_max   = (ctr & LO_MASK) == LO_MASK;
    assign issue_ok     = !wrap_err;
    assign ctr_wrap_err = wrap_err;
`else
    assign issue_ok = 1'b1;
`endif

    // Outstanding keystream (buffered plus requested) bounds request issue, so
    // every response always has a FIFO slot.
    assign credit_used   = {1'b0, fifo_count} + {1'b0, in_flight};
    assign req_fire      = aes_req_valid && aes_req_ready;
    assign s_fire        = s_valid && s_ready;
    assign push          = aes_resp_valid && (state == RUN);
    assign pop           = s_fire;
    assign resp_dec      = aes_resp_valid && (in_flight != '0);
    assign ctr_inc       = (ctr & ~LO_MASK) | ((ctr + 128'd1) & LO_MASK);
    assign aes_req_block = ctr;
    assign aes_key       = key_reg;
    assign xor_data      = s_data ^ ks_mem[rd_ptr];

    // Zero the bytes that the keep mask marks invalid (keep bit k covers data[8k+7:8k]).
    always_comb begin
        masked_data = '0;
        for (int k = 0; k < 16; k++) begin
            if (s_keep[k]) begin
                masked_data[8*k +: 8] = xor_data[8*k +: 8];
            end
        end
    end

    // Next-state and state-derived handshake outputs.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        aes_req_valid = 1'b0;
        s_ready       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy          = 1'b1;
                aes_req_valid = issue_ok && (credit_used < DEPTH_C);
                s_ready       = (fifo_count != '0) && (!m_valid || m_ready);
                if (s_valid && s_ready && s_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if ((in_flight == '0) && !m_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter and key capture on start; counter field advances per accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr      <= '0;
            key_reg  <= '0;
`ifdef AES_CTR_WRAP_ERR_EN
            wrap_err <= 1'b0;
`endif
        end else if ((state == IDLE) && start) begin
            ctr      <= iv;
            key_reg  <= key_i;
`ifdef AES_CTR_WRAP_ERR_EN
            wrap_err <= 1'b0;
`endif
        end else if (req_fire) begin
`ifdef AES_CTR_WRAP_ERR_EN
            // The all-ones block itself is valid; only the increment past it is refused.
            if (ctr_at_max) begin
                wrap_err <= 1'b1;
            end else begin
                ctr <= ctr_inc;
            end
`else
            ctr <= ctr_inc;
`endif
        end
    end

    // Requests accepted by the core but not yet answered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight <= '0;
        end else if (req_fire && !resp_dec) begin
            in_flight <= in_flight + CNT_W'(1);
        end else if (!req_fire && resp_dec) begin
            in_flight <= in_flight - CNT_W'(1);
        end
    end

    // Keystream FIFO; flushed throughout DRAIN so late responses are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < KS_DEPTH; i++) begin
                ks_mem[i] <= '0;
            end
        end else if (state == DRAIN) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                ks_mem[wr_ptr] <= aes_resp_block;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    // Output register: load on input handshake, release on downstream accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (s_fire) begin
            m_valid <= 1'b1;
            m_data  <= masked_data;
            m_keep  <= s_keep;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
